// File: rtl/mul_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier: default width, FSM encoding
// and a constant clog2 used to size the iteration counter.
package mul_shift_add_pkg;

   localparam int DEF_WIDTH = 32;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CALC = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/mul_shift_add_if.sv
// Start/busy/done operand and result bundle between a controller (master)
// and the iterative multiplier (slave).
interface mul_shift_add_if #(
   parameter int WIDTH = mul_shift_add_pkg::DEF_WIDTH
);

   logic                 start;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start,
      output multiplicand,
      output multiplier,
      input  busy,
      input  done,
      input  product
   );

   modport slave (
      input  start,
      input  multiplicand,
      input  multiplier,
      output busy,
      output done,
      output product
   );

endinterface

// File: rtl/mul_shift_add.sv
// Iterative unsigned shift-and-add multiplier, one multiplier bit per clock.
// Optional build macro MUL_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are zero.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | waiting for start; done pulses here for one cycle
// ST_CALC | accumulating partial products, one bit per edge
module mul_shift_add
   import mul_shift_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   mul_shift_add_if.slave  bus
);

   localparam int CW = clog2(WIDTH) + 1;
   localparam int PW = 2 * WIDTH;

   state_t             state,     state_nxt;
   logic [PW-1:0]      acc,       acc_nxt;
   logic [PW-1:0]      mcand_sh,  mcand_nxt;
   logic [WIDTH-1:0]   mplier_sh, mplier_nxt;
   logic [CW-1:0]      count,     count_nxt;
   logic               busy_q,    busy_nxt;
   logic               done_q,    done_nxt;
   logic [PW-1:0]      product_q, product_nxt;
   logic [PW-1:0]      sum;
   logic               last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         mcand_sh  <= '0;
         mplier_sh <= '0;
         count     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         acc       <= acc_nxt;
         mcand_sh  <= mcand_nxt;
         mplier_sh <= mplier_nxt;
         count     <= count_nxt;
         busy_q    <= busy_nxt;
         done_q    <= done_nxt;
         product_q <= product_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      acc_nxt     = acc;
      mcand_nxt   = mcand_sh;
      mplier_nxt  = mplier_sh;
      count_nxt   = count;
      busy_nxt    = busy_q;
      done_nxt    = 1'b0;
      product_nxt = product_q;
      sum         = acc;
      last        = 1'b0;

      case (state)
         ST_IDLE: begin
            if (bus.start) begin
               acc_nxt    = '0;
               mcand_nxt  = {{WIDTH{1'b0}}, bus.multiplicand};
               mplier_nxt = bus.multiplier;
               count_nxt  = '0;
               busy_nxt   = 1'b1;
               state_nxt  = ST_CALC;
            end
         end
         ST_CALC: begin
            // Both operands fit in WIDTH bits, so the 2*WIDTH accumulator never wraps.
            sum        = mplier_sh[0] ? (acc + mcand_sh) : acc;
            acc_nxt    = sum;
            mcand_nxt  = mcand_sh << 1;
            mplier_nxt = mplier_sh >> 1;
            count_nxt  = count + CW'(1);
`ifdef MUL_EARLY_TERM_EN
            last       = (count == CW'(WIDTH - 1)) || (mplier_nxt == '0);
`else
            last       = (count == CW'(WIDTH - 1));
`endif
            if (last) begin
               product_nxt = sum;
               done_nxt    = 1'b1;
               busy_nxt    = 1'b0;
               state_nxt   = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add: a cycle-count/arithmetic model checked every cycle,
// plus directed vectors with literal products and latencies.
module tb_mul_shift_add;

   localparam int W     = 32;
   localparam int LIMIT = 100;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   mul_shift_add_if #(.WIDTH(W)) bus ();

   mul_shift_add #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: latency and product derived directly from the operands.
   bit               m_busy;
   bit               m_done;
   logic [2*W-1:0]   m_prod;
   int               m_left;
   logic [W-1:0]     m_a;
   logic [W-1:0]     m_b;

   function automatic int lat_of(input logic [W-1:0] b);
`ifdef MUL_EARLY_TERM_EN
      int n;
      n = 0;
      for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
      return (n == 0) ? 1 : n;
`else
      return W;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_prod = '0;
         m_left = 0;
      end else if (m_busy) begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_prod = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
         end
      end else begin
         m_done = 1'b0;
         if (bus.start) begin
            m_a    = bus.multiplicand;
            m_b    = bus.multiplier;
            m_busy = 1'b1;
            m_left = lat_of(bus.multiplier);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("busy",    {{(2*W-1){1'b0}}, bus.busy}, {{(2*W-1){1'b0}}, m_busy});
         chk("done",    {{(2*W-1){1'b0}}, bus.done}, {{(2*W-1){1'b0}}, m_done});
         chk("product", bus.product, m_prod);
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      bus.start        = 1'b1;
      bus.multiplicand = a;
      bus.multiplier   = b;
      @(negedge clk);
      bus.start        = 1'b0;
      bus.multiplicand = $urandom;
      bus.multiplier   = $urandom;
   endtask

   task automatic wait_done(input string nm, output int n);
      n = 0;
      while (!bus.done && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      if (!bus.done) begin
         errors++;
         $display("FAIL %s_timeout: no done within %0d cycles", nm, LIMIT);
      end
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] lit_p, input int lat_full, input int lat_early,
                     input string nm);
      int n;
      int exp_lat;
`ifdef MUL_EARLY_TERM_EN
      exp_lat = lat_early;
`else
      exp_lat = lat_full;
`endif
      issue(a, b);
      wait_done(nm, n);
      chk({nm, "_lat"},  64'(n), 64'(exp_lat));
      chk({nm, "_prod"}, bus.product, lit_p);
   endtask

   initial begin
      int n0;
      int m;
      bit seen;
      logic [W-1:0] ign_b;
      logic [2*W-1:0] ign_p;

      bus.start        = 1'b0;
      bus.multiplicand = '0;
      bus.multiplier   = '0;
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy",    {63'd0, bus.busy}, 64'd0);
      chk("rst_done",    {63'd0, bus.done}, 64'd0);
      chk("rst_product", bus.product, 64'd0);
      #1 rst = 1'b0;
      @(negedge clk);

      op(32'd7, 32'd6, 64'd42, 32, 3, "7x6");
      @(negedge clk);
      chk("7x6_done_low", {63'd0, bus.done}, 64'd0);

      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32, 32, "ones");
      @(negedge clk);

      // Second start mid-operation must be ignored.
`ifdef MUL_EARLY_TERM_EN
      ign_b = 32'h8000_0005;
      ign_p = 64'h0000_0001_8000_000F;
`else
      ign_b = 32'd5;
      ign_p = 64'd15;
`endif
      issue(32'd3, ign_b);
      n0 = 0;
      repeat (9) begin
         @(negedge clk);
         n0++;
      end
      bus.start        = 1'b1;
      bus.multiplicand = 32'd9;
      bus.multiplier   = 32'd9;
      @(negedge clk);
      n0++;
      bus.start = 1'b0;
      wait_done("ignore", m);
      chk("ignore_lat",  64'(n0 + m), 64'd32);
      chk("ignore_prod", bus.product, ign_p);
      @(negedge clk);

      // Reset in mid-operation.
      issue(32'd1000, 32'd1000);
      repeat (14) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy",    {63'd0, bus.busy}, 64'd0);
      chk("abort_done",    {63'd0, bus.done}, 64'd0);
      chk("abort_product", bus.product, 64'd0);
      @(negedge clk);
      #1 rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      chk("abort_no_done", {63'd0, seen}, 64'd0);
      op(32'd2, 32'd3, 64'd6, 32, 2, "2x3");
      @(negedge clk);

      // Back-to-back: second start issued in the done cycle.
      op(32'd4,  32'd4,  64'd16,  32, 3, "b2b_first");
      op(32'd12, 32'd11, 64'd132, 32, 4, "b2b_second");
      @(negedge clk);

      op(32'd5, 32'd3, 64'd15, 32, 2, "5x3");
      @(negedge clk);
      op(32'd8, 32'd0, 64'd0, 32, 1, "8x0");
      @(negedge clk);
      op(32'd0, 32'd7, 64'd0, 32, 3, "0x7");
      @(negedge clk);
      op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 32, 2, "msb_x2");
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit %0d", $time, 200000);
      $fatal(1);
   end

endmodule

// File: doc/mul_shift_add.md
Name: mul_shift_add

Overview:
- Iterative unsigned multiplier: product = multiplicand * multiplier.
- Uses shift-and-add, one multiplier bit per clock. It is the inverse-operation companion to the team's repeated-subtraction divider.
- Sits beside the divider in the arithmetic datapath.
- Uses a start/busy/done handshake, so a controller can issue operands and wait on a one-cycle completion pulse.

Parameters:
- WIDTH, 32, operand width in bits. Product width is 2*WIDTH. Legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- multiplicand  input  WIDTH  unsigned operand A; captured on the accepting edge.
- multiplier  input  WIDTH  unsigned operand B; captured on the accepting edge.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; product is valid from this cycle.
- product  output  2*WIDTH  registered result; holds until the next done or reset.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal acc, mcand_sh, mplier_sh and count all cleared.
  - Reset asserted mid-operation aborts it immediately. No done is issued, and the partial result is discarded.
- States: IDLE, CALC. Registered outputs only.
- IDLE:
  - done is low unless this is the cycle right after completion.
  - If start=1 at edge E0:
    - acc <= 0.
    - mcand_sh <= zero-extended multiplicand (2*WIDTH bits).
    - mplier_sh <= multiplier.
    - count <= 0, busy <= 1, state <= CALC.
  - If start=0, all registers hold.
- CALC, each edge:
  - If mplier_sh[0]=1, acc <= acc + mcand_sh. This is a 2*WIDTH-bit add and cannot overflow.
  - mcand_sh <= mcand_sh << 1.
  - mplier_sh <= mplier_sh >> 1.
  - count <= count + 1.
- Completion: the edge on which count == WIDTH-1 is the last iteration. On that edge:
  - product <= final acc value, including that edge's add.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start at E0 gives done high after edge E(WIDTH). busy is high from E0 through E(WIDTH).
- done is high for exactly one cycle and deasserts at the next edge.
- start while busy=1 is ignored: no queueing, operands not sampled.
- start during the done cycle is accepted, since the state is IDLE. This gives back-to-back operations with no bubble.
- Operand inputs may change freely after the accepting edge.
- Width rules:
  - count is clog2(WIDTH)+1 bits.
  - All arithmetic is unsigned, with no truncation of product.
- Boundaries:
  - Either operand zero gives product 0 after the full latency (unless the optional feature is compiled in).
  - All-ones x all-ones gives 2^(2W) - 2^(W+1) + 1.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- Defined: completion also occurs on the CALC edge where the next mplier_sh (after the shift) is zero. Product, done and busy update exactly as on normal completion, so latency is the bit-length of multiplier, minimum 1 cycle.
  - multiplier=0: done after E1, product=0.
- Undefined: fixed WIDTH-cycle latency regardless of operand values.

Decomposition:
- Shared header package mul_pkg.vh holds:
  - state encoding localparams ST_IDLE=1'b0, ST_CALC=1'b1;
  - default WIDTH;
  - a clog2 constant function.
- No sub-module is needed; the shift-add datapath and the 2-state FSM live in one module.

Test Plan:
- WIDTH=32, start with 7 x 6 -> busy high 32 cycles; done pulses after E32; product=42; done low at the next edge.
- 0xFFFFFFFF x 0xFFFFFFFF -> product=0xFFFFFFFE00000001 after E32.
- Start 3 x 5; pulse start again at E10 with 9 x 9 -> second request ignored; product=15 after E32.
- Start 1000 x 1000; assert rst at E15 -> busy=0, done=0, product=0 immediately. No done follows. Then 2 x 3 -> product=6.
- 4 x 4, then start asserted in the done cycle with 12 x 11 -> first product=16; second done exactly 32 cycles later with product=132.
- MUL_EARLY_TERM_EN: 5 x 3 -> done after E2, product=15; 8 x 0 -> done after E1, product=0.
